bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 The block SHALL have parameter DIGITS, default 5, giving the number of BCD digits in the input word.
REQ-002 The block SHALL have parameter BIN_W, default 17, giving the binary result width (99999 = 0x1869F fits in 17 bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port dec, input, 4*DIGITS bits: the packed BCD operand; the most significant digit is in the top nibble.
REQ-006 The block SHALL have port in_valid, input, 1 bit: dec is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-008 The block SHALL have port bin, output, BIN_W bits: the binary result.
REQ-009 The block SHALL have port out_valid, output, 1 bit: bin (and err) are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-011 The block SHALL have port err, output, 1 bit: the result was computed from at least one non-decimal digit.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-014 An operand SHALL be accepted at the edge where in_valid=1 and in_ready=1.
REQ-015 On acceptance (edge k), the block SHALL capture dec, clear the accumulator and the digit counter, and go to CONV.
REQ-016 Each CONV cycle SHALL update acc <= acc*10 + digit[cnt], processing the most significant digit first, with *10 formed as (acc<<3)+(acc<<1) and no multiplier.
REQ-017 After DIGITS CONV cycles the block SHALL go to DONE, so bin is valid at edge k+DIGITS (k+5 by default).
REQ-018 Accumulator arithmetic SHALL be BIN_W+4 bits wide internally; bin SHALL be the low BIN_W bits.
REQ-019 bin and err SHALL be held stable in DONE until out_ready=1.
REQ-020 On out_valid=1 and out_ready=1 the block SHALL return to IDLE at that edge, so in_ready=1 in the following cycle; there SHALL be no back-to-back acceptance in the same cycle.
REQ-021 in_valid while the block is not in IDLE SHALL be ignored, and dec changes SHALL have no effect after capture.
REQ-022 bin SHALL hold its last result in IDLE and CONV until overwritten at the next DONE entry.

Reset
REQ-023 On rst_n=0 the block SHALL immediately enter IDLE, with bin=0, out_valid=0, err=0, accumulator=0 and counter=0; in_ready SHALL be 1 once reset is released.
REQ-024 A reset asserted during CONV or DONE SHALL abort the conversion, and no out_valid pulse SHALL follow.

Configuration
REQ-025 Non-decimal digit detection SHALL be compiled in or out with the macro BCD2BIN_DIGIT_CHECK_EN.
REQ-026 With BCD2BIN_DIGIT_CHECK_EN defined, err SHALL be set in DONE if any captured digit is greater than 9, and bin SHALL still be the raw acc*10+digit result.
REQ-027 Without BCD2BIN_DIGIT_CHECK_EN, err SHALL be tied to 0 and the port SHALL remain present.

Structure
REQ-028 A package bcd2bin_pkg SHALL hold the DIGITS and BIN_W defaults, the state enum (IDLE/CONV/DONE) and the constant 4'd9.
REQ-029 One sub-module, bcd_mac10, SHALL implement the combinational acc*10+digit step, plus the digit>9 flag, and be instantiated once.

Verification
REQ-030 Apply dec=0x99999 with out_ready=1 -> bin=0x1869F, out_valid high at edge k+5, err=0.
REQ-031 Apply dec=0x04096 -> bin=0x01000; apply dec=0x00000 -> bin=0, with exactly one out_valid cycle each.
REQ-032 Hold out_ready=0 for 10 cycles after DONE -> bin and out_valid stay constant and in_ready=0; then raise out_ready -> in_ready=1 on the next cycle.
REQ-033 Change in_valid/dec during CONV -> no effect; result matches the first operand.
REQ-034 Assert rst_n=0 at CONV cycle 3 -> all outputs 0 at once and no out_valid after release; a new 0x12345 then gives 0x03039.
REQ-035 With the macro defined, dec=0x0000A -> bin=0x0000A, err=1; without the macro -> bin=0x0000A, err=0.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared defaults, state encoding and constants for the BCD-to-binary converter.
package bcd2bin_pkg;

   localparam int DIGITS_DEF = 5;
   localparam int BIN_W_DEF  = 17;

   localparam logic [3:0] DEC_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bcd2bin_mac10.sv
// One Horner step of the conversion: acc*10 + digit built from shifts and adds,
// with a flag for a digit that is not a valid decimal value.
module bcd_mac10
   import bcd2bin_pkg::*;
#(
   parameter int ACC_W = 21
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [3:0]       digit_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             bad_o
);

   assign acc_o = (acc_i << 3) + (acc_i << 1) + {{(ACC_W-4){1'b0}}, digit_i};
   assign bad_o = (digit_i > DEC_MAX);

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
// Non-decimal digit reporting is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin
   import bcd2bin_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   dec,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BIN_W-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err
);

   localparam int ACC_W = BIN_W + 4;
   localparam int CNT_W = $clog2(DIGITS + 1);

`ifdef BCD2BIN_DIGIT_CHECK_EN
   localparam logic DigitCheckEn = 1'b1;
`else
   localparam logic DigitCheckEn = 1'b0;
`endif

   state_e                state_q, state_d;
   logic [4*DIGITS-1:0]   dec_q, dec_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIN_W-1:0]      bin_q, bin_d;
   logic                  err_q, err_d;
   logic                  bad_q, bad_d;

   logic [ACC_W-1:0]      macAcc;
   logic                  macBad;

   // The captured word shifts left each cycle so the current digit is always the top nibble.
   bcd_mac10 #(.ACC_W(ACC_W)) u_mac (
      .acc_i   (acc_q),
      .digit_i (dec_q[4*DIGITS-1 -: 4]),
      .acc_o   (macAcc),
      .bad_o   (macBad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dec_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      err_d   = err_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CONV;
               dec_d   = dec;
               acc_d   = '0;
               cnt_d   = '0;
               bad_d   = 1'b0;
            end
         end
         CONV: begin
            acc_d = macAcc;
            dec_d = dec_q << 4;
            bad_d = bad_q | macBad;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d = DONE;
               bin_d   = macAcc[BIN_W-1:0];
               err_d   = DigitCheckEn & (bad_q | macBad);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign bin       = bin_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: expected results are queued when an operand is driven
// and popped when out_valid is seen. Honours BCD2BIN_DIGIT_CHECK_EN for the err column.
module tb_bcd2bin;
   import bcd2bin_pkg::*;

   localparam int DIGITS = 5;
   localparam int BIN_W  = 17;
   localparam int LAT    = 5;
   localparam int BOUND  = 40;

   typedef struct packed {
      logic [BIN_W-1:0] bin;
      logic             err;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [4*DIGITS-1:0] dec = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [BIN_W-1:0]    bin;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                err;

   int   nCompared = 0;
   int   nMismatched = 0;
   exp_t expQ[$];

   bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dec       (dec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer Horner evaluation over the nibbles.
   function automatic exp_t model(input logic [4*DIGITS-1:0] d);
      int   acc;
      logic bad;
      logic [3:0] nib;
      exp_t r;
      acc = 0;
      bad = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = d[i*4 +: 4];
         acc = acc * 10 + int'(nib);
         if (nib > 4'd9) bad = 1'b1;
      end
      r.bin = acc[BIN_W-1:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
      r.err = bad;
`else
      r.err = 1'b0;
`endif
      return r;
   endfunction

   // Handshake only: present one operand in IDLE and return just after the accepting edge.
   task automatic drive_op(input logic [4*DIGITS-1:0] d);
      @(negedge clk);
      dec      = d;
      in_valid = 1'b1;
      expQ.push_back(model(d));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after acceptance until out_valid is seen #1 after an edge.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (cycles < BOUND) begin
         @(posedge clk);
         cycles++;
         #1;
         if (out_valid) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      nCompared++;
      if ({bin, out_valid, err} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs: got bin=%h ov=%b err=%b required all 0", bin, out_valid, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nCompared++;
      if (in_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_max;
      int   cyc;
      exp_t e;
      out_ready = 1'b1;
      drive_op(20'h99999);
      wait_valid(cyc);
      nCompared++;
      if (cyc !== LAT) begin
         nMismatched++;
         $display("[TB] FAIL max_latency: got %0d edges required %0d", cyc, LAT);
      end
      e = expQ.pop_front();
      nCompared++;
      if (bin !== e.bin || bin !== 17'h1869F) begin
         nMismatched++;
         $display("[TB] FAIL max_bin: got %h required %h", bin, 17'h1869F);
      end
      nCompared++;
      if (err !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL max_err: got %b required 0", err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_values;
      int   cyc;
      exp_t e;
      logic [4*DIGITS-1:0] ops [2];
      ops[0] = 20'h04096;
      ops[1] = 20'h00000;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_op(ops[i]);
         wait_valid(cyc);
         e = expQ.pop_front();
         nCompared++;
         if (cyc !== LAT || bin !== e.bin || err !== e.err) begin
            nMismatched++;
            $display("[TB] FAIL value_%h: got bin=%h err=%b at %0d required bin=%h err=%b at %0d",
                     ops[i], bin, err, cyc, e.bin, e.err, LAT);
         end
         @(posedge clk);
         #1;
         nCompared++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL single_pulse_%h: got ov=%b ir=%b required ov=0 ir=1", ops[i], out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      int   cyc;
      exp_t e;
      logic [BIN_W-1:0] held;
      int   bad;
      out_ready = 1'b0;
      drive_op(20'h31415);
      wait_valid(cyc);
      e = expQ.pop_front();
      held = bin;
      nCompared++;
      if (bin !== e.bin) begin
         nMismatched++;
         $display("[TB] FAIL bp_bin: got %h required %h", bin, e.bin);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bin !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      nCompared++;
      if (bad != 0) begin
         nMismatched++;
         $display("[TB] FAIL bp_hold: got %0d unstable cycles required 0", bad);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      nCompared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL bp_release: got ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_ignore_during_conv;
      int   cyc;
      exp_t e;
      out_ready = 1'b1;
      drive_op(20'h12345);
      in_valid = 1'b1;
      dec      = 20'h99999;
      @(posedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dec      = 20'h00007;
      wait_valid(cyc);
      e = expQ.pop_front();
      nCompared++;
      if (bin !== e.bin || bin !== 17'h03039 || cyc !== LAT - 2) begin
         nMismatched++;
         $display("[TB] FAIL ignore_conv: got bin=%h after %0d required bin=%h after %0d", bin, cyc, e.bin, LAT - 2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort;
      int   cyc;
      int   seen;
      exp_t e;
      out_ready = 1'b1;
      drive_op(20'h55555);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      e = expQ.pop_front();
      #1;
      nCompared++;
      if ({bin, out_valid, err} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL abort_outputs: got bin=%h ov=%b err=%b required all 0", bin, out_valid, err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      nCompared++;
      if (seen != 0) begin
         nMismatched++;
         $display("[TB] FAIL abort_no_valid: got %0d valid cycles required 0", seen);
      end
      drive_op(20'h12345);
      wait_valid(cyc);
      e = expQ.pop_front();
      nCompared++;
      if (cyc !== LAT || bin !== 17'h03039 || bin !== e.bin) begin
         nMismatched++;
         $display("[TB] FAIL abort_recover: got bin=%h at %0d required %h at %0d", bin, cyc, e.bin, LAT);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_nondecimal;
      int   cyc;
      exp_t e;
      out_ready = 1'b1;
      drive_op(20'h0000A);
      wait_valid(cyc);
      e = expQ.pop_front();
      nCompared++;
      if (bin !== 17'h0000A || bin !== e.bin) begin
         nMismatched++;
         $display("[TB] FAIL nondec_bin: got %h required %h", bin, e.bin);
      end
      nCompared++;
      if (err !== e.err) begin
         nMismatched++;
         $display("[TB] FAIL nondec_err: got %b required %b", err, e.err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int   cyc;
      exp_t e;
      logic [4*DIGITS-1:0] d;
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         for (int j = 0; j < DIGITS; j++) begin
            d[j*4 +: 4] = 4'($urandom_range((n == 7) ? 15 : 9, 0));
         end
         drive_op(d);
         wait_valid(cyc);
         e = expQ.pop_front();
         nCompared++;
         if (cyc !== LAT || bin !== e.bin || err !== e.err) begin
            nMismatched++;
            $display("[TB] FAIL b2b_%h: got bin=%h err=%b at %0d required bin=%h err=%b at %0d",
                     d, bin, err, cyc, e.bin, e.err, LAT);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_values();
      test_backpressure();
      test_ignore_during_conv();
      test_reset_abort();
      test_nondecimal();
      test_back_to_back();
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d left required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
